// File: rtl/fir3_lane_serializer_pkg.sv
//------------------------------------------------------------------------------
// fir3_pkg : shared types and defaults for the 3-lane FIR output serializer
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package fir3_pkg;
  localparam int LANES     = 3;
  localparam int DEF_IN_W  = 64;
  localparam int DEF_OUT_W = 16;

  typedef logic [1:0] lane_idx_t;

  // Lanes are held at the widest supported accumulator width (IN_W <= DEF_IN_W).
  typedef struct packed {
    logic signed [DEF_IN_W-1:0] din0;
    logic signed [DEF_IN_W-1:0] din1;
    logic signed [DEF_IN_W-1:0] din2;
  } triple_t;
endpackage

`default_nettype wire

// File: rtl/fir3_lane_serializer_if.sv
//------------------------------------------------------------------------------
// fir3_lane_serializer_if : triple input bus and serial valid/ready output bus
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface fir3_lane_serializer_if #(
  parameter int IN_W  = 64,
  parameter int OUT_W = 16
) ();
  logic                    in_valid;
  logic                    in_ready;
  logic signed [IN_W-1:0]  din0;
  logic signed [IN_W-1:0]  din1;
  logic signed [IN_W-1:0]  din2;
  logic signed [OUT_W-1:0] dout;
  logic                    dout_valid;
  logic                    dout_ready;

  modport master (
    output in_valid, din0, din1, din2, dout_ready,
    input  in_ready, dout, dout_valid
  );

  modport slave (
    input  in_valid, din0, din1, din2, dout_ready,
    output in_ready, dout, dout_valid
  );
endinterface

`default_nettype wire

// File: rtl/fir3_lane_serializer_round_sat.sv
//------------------------------------------------------------------------------
// fir3_round_sat : round-half-up right shift followed by signed saturation
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fir3_round_sat #(
  parameter int IN_W  = 64,
  parameter int OUT_W = 16,
  parameter int SHIFT = 15
) (
  input  logic signed [IN_W-1:0]  x,
  output logic signed [OUT_W-1:0] y,
  output logic                    clamped
);
  localparam logic signed [IN_W:0] c_rnd =
    (IN_W+1)'(SHIFT > 0 ? 1 : 0) << (SHIFT > 0 ? SHIFT - 1 : 0);
  localparam logic signed [IN_W:0] c_max = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W:0] c_min = {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [IN_W:0] w_t;
  logic signed [IN_W:0] w_s;
  logic                 w_hi;
  logic                 w_lo;

  // One guard bit keeps the rounding add from overflowing.
  assign w_t  = {x[IN_W-1], x} + c_rnd;
  assign w_s  = w_t >>> SHIFT;
  assign w_hi = (w_s > c_max);
  assign w_lo = (w_s < c_min);

  always_comb begin
    y = w_s[OUT_W-1:0];
    if (w_hi) begin
      y = c_max[OUT_W-1:0];
    end else if (w_lo) begin
      y = c_min[OUT_W-1:0];
    end
    clamped = w_hi | w_lo;
  end
endmodule

`default_nettype wire

// File: rtl/fir3_lane_serializer.sv
//------------------------------------------------------------------------------
// fir3_lane_serializer : buffers lane triples, rounds/saturates, emits lane 0,1,2
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fir3_lane_serializer
  import fir3_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int SHIFT = 15,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  fir3_lane_serializer_if.slave        bus,
  input  logic                         sat_clr,
  output logic                         sat_flag,
  output logic [15:0]                  drop_cnt
);
  localparam int        c_pw   = $clog2(DEPTH);
  localparam int        c_cw   = $clog2(DEPTH + 1);
  localparam lane_idx_t c_last = lane_idx_t'(LANES - 1);

  typedef logic [c_pw-1:0] ptr_t;

  triple_t                 r_mem [DEPTH];
  ptr_t                    r_wptr;
  ptr_t                    r_rptr;
  logic [c_cw-1:0]         r_count;
  lane_idx_t               r_lsel;
  logic signed [OUT_W-1:0] r_dout;
  logic                    r_dout_valid;
  logic                    r_sat;
  logic [15:0]             r_drop;

  logic                    w_full;
  logic                    w_empty;
  logic                    w_push;
  logic                    w_load;
  logic                    w_take;
  logic                    w_pop;
  triple_t                 w_head;
  logic signed [IN_W-1:0]  w_lane;
  logic signed [OUT_W-1:0] w_sample;
  logic                    w_clamped;

  function automatic ptr_t next_ptr(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_full  = (r_count == c_cw'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = bus.in_valid && !w_full;
  assign w_load  = !r_dout_valid || bus.dout_ready;
  assign w_take  = w_load && !w_empty;
  assign w_pop   = w_take && (r_lsel == c_last);
  assign w_head  = r_mem[r_rptr];

  always_comb begin
    unique case (r_lsel)
      2'd0:    w_lane = IN_W'(w_head.din0);
      2'd1:    w_lane = IN_W'(w_head.din1);
      default: w_lane = IN_W'(w_head.din2);
    endcase
  end

  fir3_round_sat #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_round_sat (
    .x       (w_lane),
    .y       (w_sample),
    .clamped (w_clamped)
  );

  // Storage needs no reset: only entries covered by r_count are ever read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= '{din0: DEF_IN_W'(bus.din0),
                         din1: DEF_IN_W'(bus.din1),
                         din2: DEF_IN_W'(bus.din2)};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= next_ptr(r_wptr);
      if (w_pop)  r_rptr <= next_ptr(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_lsel       <= '0;
    end else if (w_load) begin
      if (!w_empty) begin
        r_dout       <= w_sample;
        r_dout_valid <= 1'b1;
        r_lsel       <= (r_lsel == c_last) ? '0 : r_lsel + 1'b1;
      end else begin
        r_dout_valid <= 1'b0;
      end
    end
  end

  // A clamp on the loading edge outranks a simultaneous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sat  <= 1'b0;
      r_drop <= '0;
    end else begin
      if (w_take && w_clamped) begin
        r_sat <= 1'b1;
      end else if (sat_clr) begin
        r_sat <= 1'b0;
      end
      if (bus.in_valid && w_full && (r_drop != 16'hFFFF)) begin
        r_drop <= r_drop + 16'd1;
      end
    end
  end

  assign bus.in_ready   = !w_full;
  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_dout_valid;
  assign sat_flag       = r_sat;
  assign drop_cnt       = r_drop;
endmodule

`default_nettype wire

// File: tb/tb_fir3_lane_serializer.sv
//------------------------------------------------------------------------------
// tb_fir3_lane_serializer : randomized + directed bench against a sample-level model
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_fir3_lane_serializer;
  localparam int c_depth = 2;

  logic        clk;
  logic        rst;
  logic        sat_clr;
  logic        sat_flag;
  logic [15:0] drop_cnt;

  fir3_lane_serializer_if #(.IN_W(64), .OUT_W(16)) bus ();

  fir3_lane_serializer #(
    .IN_W  (64),
    .OUT_W (16),
    .SHIFT (15),
    .DEPTH (c_depth)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .sat_clr  (sat_clr),
    .sat_flag (sat_flag),
    .drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: every accepted-but-unconsumed sample in stream order.
  int  m_q[$];
  bit  m_cq[$];
  bit  m_dv;
  bit  m_sat;
  int  m_drop;
  int  got[$];
  int  got_t[$];
  int  cyc = 0;

  task automatic chk(input string tag, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic longint shr_round(input longint x);
    return (x >>> 15) + ((x >>> 14) & 64'sd1);
  endfunction

  function automatic int ref_val(input longint x);
    longint y;
    y = shr_round(x);
    if (y > 32767)  return 32767;
    if (y < -32768) return -32768;
    return int'(y);
  endfunction

  function automatic bit ref_clamp(input longint x);
    longint y;
    y = shr_round(x);
    return (y > 32767) || (y < -32768);
  endfunction

  function automatic bit model_full();
    int unl;
    unl = m_q.size() - int'(m_dv);
    return ((unl + 2) / 3) >= c_depth;
  endfunction

  task automatic drive(input bit v, input longint a, input longint b, input longint c);
    bus.in_valid = v;
    bus.din0 = a;
    bus.din1 = b;
    bus.din2 = c;
  endtask

  // Check outputs, advance the model across the next rising edge, land on the negedge.
  task automatic step();
    int  unl;
    bit  full;
    bit  set;
    full = model_full();
    chk("dout_valid", longint'(bus.dout_valid), longint'(m_dv));
    if (m_dv && m_q.size() > 0) chk("dout", longint'($signed(bus.dout)), longint'(m_q[0]));
    chk("in_ready", longint'(bus.in_ready), longint'(!full));
    chk("sat_flag", longint'(sat_flag), longint'(m_sat));
    chk("drop_cnt", longint'(drop_cnt), longint'(m_drop));
    if (bus.dout_valid && bus.dout_ready) begin
      got.push_back(int'($signed(bus.dout)));
      got_t.push_back(cyc);
    end
    unl = m_q.size() - int'(m_dv);
    set = 1'b0;
    if (m_dv && bus.dout_ready && m_q.size() > 0) begin
      void'(m_q.pop_front());
      void'(m_cq.pop_front());
    end
    if (!m_dv || bus.dout_ready) begin
      if (unl > 0) begin
        m_dv = 1'b1;
        set  = m_cq[0];
      end else begin
        m_dv = 1'b0;
      end
    end
    if (set) m_sat = 1'b1;
    else if (sat_clr) m_sat = 1'b0;
    if (bus.in_valid) begin
      if (!full) begin
        m_q.push_back(ref_val(longint'(bus.din0)));  m_cq.push_back(ref_clamp(longint'(bus.din0)));
        m_q.push_back(ref_val(longint'(bus.din1)));  m_cq.push_back(ref_clamp(longint'(bus.din1)));
        m_q.push_back(ref_val(longint'(bus.din2)));  m_cq.push_back(ref_clamp(longint'(bus.din2)));
      end else if (m_drop < 65535) begin
        m_drop++;
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Asynchronous assertion between edges, release on a negedge.
  task automatic do_reset();
    #2 rst = 1'b0;
    drive(1'b0, 0, 0, 0);
    sat_clr = 1'b0;
    #1;
    chk("rst_dout", longint'($signed(bus.dout)), 0);
    chk("rst_dout_valid", longint'(bus.dout_valid), 0);
    chk("rst_sat_flag", longint'(sat_flag), 0);
    chk("rst_drop_cnt", longint'(drop_cnt), 0);
    m_q.delete();
    m_cq.delete();
    m_dv = 1'b0;
    m_sat = 1'b0;
    m_drop = 0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_in_ready", longint'(bus.in_ready), 1);
    @(negedge clk);
  endtask

  initial begin
    int base;
    int c0;
    int b2;
    rst = 1'b0;
    sat_clr = 1'b0;
    bus.dout_ready = 1'b1;
    drive(1'b0, 0, 0, 0);
    m_dv = 1'b0; m_sat = 1'b0; m_drop = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Mid-run reset with buffered data, drops and a saturated sample pending
    bus.dout_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 64'sd1 <<< 40, 100, 200);
      step();
    end
    drive(1'b0, 0, 0, 0);
    step();
    do_reset();
    bus.dout_ready = 1'b1;
    steps(3);

    // Single triple: value and latency
    base = got.size();
    c0 = cyc;
    drive(1'b1, 98304, 49152, -49152);
    step();
    drive(1'b0, 0, 0, 0);
    steps(6);
    chk("single_n", got.size() - base, 3);
    if (got.size() - base >= 3) begin
      chk("single_l0", got[base], 3);
      chk("single_l1", got[base+1], 2);
      chk("single_l2", got[base+2], -1);
      chk("single_lat", got_t[base] - c0, 2);
      chk("single_gap", got_t[base+2] - got_t[base], 2);
    end
    chk("single_sat", longint'(sat_flag), 0);

    // Saturation and sticky clear
    base = got.size();
    drive(1'b1, 64'sd1 <<< 40, -(64'sd1 <<< 40), 32767);
    step();
    drive(1'b0, 0, 0, 0);
    steps(6);
    chk("sat_n", got.size() - base, 3);
    if (got.size() - base >= 3) begin
      chk("sat_l0", got[base], 32767);
      chk("sat_l1", got[base+1], -32768);
      chk("sat_l2", got[base+2], 1);
    end
    chk("sat_set", longint'(sat_flag), 1);
    sat_clr = 1'b1;
    step();
    sat_clr = 1'b0;
    step();
    chk("sat_cleared", longint'(sat_flag), 0);

    // Backpressure and drop
    base = got.size();
    bus.dout_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, (i*3 + 1) * 32768, (i*3 + 2) * 32768, (i*3 + 3) * 32768);
      step();
      if (i == 1) chk("bp_in_ready", longint'(bus.in_ready), 0);
    end
    drive(1'b0, 0, 0, 0);
    step();
    chk("bp_drop", longint'(drop_cnt), 2);
    chk("bp_hold", longint'($signed(bus.dout)), 1);
    bus.dout_ready = 1'b1;
    steps(8);
    chk("bp_n", got.size() - base, 6);
    for (int i = 0; i < 6; i++)
      if (base + i < got.size()) chk("bp_order", got[base+i], i + 1);

    // Reset mid-triple
    base = got.size();
    drive(1'b1, 7 * 32768, 8 * 32768, 9 * 32768);
    step();
    drive(1'b0, 0, 0, 0);
    steps(2);
    chk("mid_lane1", longint'($signed(bus.dout)), 8);
    do_reset();
    steps(4);
    chk("mid_no_lane2", got.size() - base, 1);
    b2 = got.size();
    drive(1'b1, 11 * 32768, 12 * 32768, 13 * 32768);
    step();
    drive(1'b0, 0, 0, 0);
    steps(5);
    chk("mid_restart_n", got.size() - b2, 3);
    if (got.size() > b2) chk("mid_restart_l0", got[b2], 11);

    // Sustained stream, one triple every three cycles
    base = got.size();
    for (int t = 0; t < 10; t++) begin
      drive(1'b1, (3*t) * 32768, (3*t + 1) * 32768, (3*t + 2) * 32768);
      step();
      drive(1'b0, 0, 0, 0);
      steps(2);
    end
    steps(4);
    chk("ramp_n", got.size() - base, 30);
    if (got.size() - base >= 30) begin
      for (int i = 0; i < 30; i++) chk("ramp_val", got[base+i], i);
      chk("ramp_gapfree", got_t[base+29] - got_t[base], 29);
    end
    chk("ramp_drop", longint'(drop_cnt), 0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      longint v[3];
      for (int l = 0; l < 3; l++) begin
        if ($urandom_range(0, 3) == 0) v[l] = longint'({$urandom, $urandom});
        else v[l] = longint'($signed($urandom_range(0, 2097151))) - 64'sd1048576;
      end
      drive($urandom_range(0, 99) < 45, v[0], v[1], v[2]);
      bus.dout_ready = ($urandom_range(0, 99) < 70);
      sat_clr = ($urandom_range(0, 99) < 10);
      step();
    end
    drive(1'b0, 0, 0, 0);
    bus.dout_ready = 1'b1;
    sat_clr = 1'b0;
    steps(12);
    chk("drain_empty", longint'(m_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
